// File: rtl/key_schedule_serial_if.sv
// Byte-stream bundle between a key-schedule engine and its host (key input, S-box port, round-key output).
// slave is the engine side; master is the host that feeds keys, serves the S-box and drains round keys.
interface key_schedule_serial_if #(
  parameter int RKEY_W = 8
);
  logic              key_load;
  logic [1:0]        key_len;
  logic [RKEY_W-1:0] key_in;
  logic              key_in_valid;
  logic [RKEY_W-1:0] sbox_in;
  logic [RKEY_W-1:0] sbox_out;
  logic [RKEY_W-1:0] rk_out;
  logic              rk_valid;
  logic              rk_ready;
  logic              rk_last;
  logic [3:0]        round_idx;
  logic              busy;
  logic              err;

  modport master (
    output key_load, key_len, key_in, key_in_valid, sbox_out, rk_ready,
    input  sbox_in, rk_out, rk_valid, rk_last, round_idx, busy, err
  );

  modport slave (
    input  key_load, key_len, key_in, key_in_valid, sbox_out, rk_ready,
    output sbox_in, rk_out, rk_valid, rk_last, round_idx, busy, err
  );
endinterface

// File: rtl/key_schedule_serial.sv
// Byte-serial AES key expansion using one shared external S-box; emits the key then all round-key bytes.
// Define KS_WIDE_KEY_EN to add AES-192/256 (32-byte store); otherwise only AES-128 is accepted.
module key_schedule_serial #(
  parameter int SBOX_LAT = 0,
  parameter int RKEY_W   = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  key_schedule_serial_if.slave bus
);

`ifdef KS_WIDE_KEY_EN
  localparam int SB = 32;
`else
  localparam int SB = 16;
`endif
  localparam bit LAT1 = (SBOX_LAT == 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t                    state, state_nx;
  // st[0] is the most recent byte; st[m] is the byte emitted m+1 transfers ago
  logic [SB-1:0][RKEY_W-1:0] st;
  logic [7:0]                cnt;
  logic [2:0]                wmod;
  logic [RKEY_W-1:0]         rcon;
  logic                      iss;
  logic                      err_q;
`ifdef KS_WIDE_KEY_EN
  logic [1:0]                len_q;
`endif

  logic              len_ok, start, nk8, rot, sub, vld, xfer, last_b, load_end;
  logic [3:0]        nr;
  logic [2:0]        wmax;
  logic [RKEY_W-1:0] old_b, src_b, t_b, dat;

  always_comb begin
    len_ok = (bus.key_len == 2'b00);
    nr     = 4'd10;
    wmax   = 3'd3;
    nk8    = 1'b0;
    old_b  = st[15];
`ifdef KS_WIDE_KEY_EN
    len_ok = (bus.key_len != 2'b11);
    case (len_q)
      2'b01: begin nr = 4'd12; wmax = 3'd5; old_b = st[23]; end
      2'b10: begin nr = 4'd14; wmax = 3'd7; old_b = st[31]; nk8 = 1'b1; end
      default: ;
    endcase
`endif
  end

  assign start    = bus.key_load && len_ok;
  assign last_b   = (cnt == {nr, 4'hF});
  assign load_end = (cnt == {3'b000, wmax, 2'b11});

  always_comb begin
    state_nx = state;
    rot      = (wmod == 3'd0);
    sub      = (state == EXPAND) && (rot || (nk8 && wmod == 3'd4));
    // RotWord: byte j of the rotated word is w[i-1][(j+1) mod 4]
    src_b    = st[3];
    if (rot) src_b = (cnt[1:0] == 2'd3) ? st[6] : st[2];
    t_b      = src_b;
    if (sub) t_b = bus.sbox_out ^ ((rot && cnt[1:0] == 2'd0) ? rcon : '0);
    vld      = 1'b0;
    dat      = '0;
    case (state)
      LOAD: begin
        vld = bus.key_in_valid;
        dat = bus.key_in;
        if (vld && bus.rk_ready && load_end) state_nx = EXPAND;
      end
      EXPAND: begin
        vld = !(LAT1 && sub && !iss);
        dat = old_b ^ t_b;
        if (vld && bus.rk_ready && last_b) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = LOAD;
    xfer = vld && bus.rk_ready;
  end

  assign bus.sbox_in   = sub ? src_b : '0;
  assign bus.rk_valid  = vld;
  assign bus.rk_out    = vld ? dat : '0;
  assign bus.rk_last   = vld && last_b;
  assign bus.round_idx = cnt[7:4];
  assign bus.busy      = (state == LOAD) || (state == EXPAND);
  assign bus.err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      st    <= '0;
      cnt   <= '0;
      wmod  <= '0;
      rcon  <= 8'h01;
      iss   <= 1'b0;
      err_q <= 1'b0;
`ifdef KS_WIDE_KEY_EN
      len_q <= 2'b00;
`endif
    end else begin
      state <= state_nx;
      err_q <= bus.key_load && !len_ok;
      // a new request overrides any transfer happening in the same cycle
      if (start) begin
        st   <= '0;
        cnt  <= '0;
        wmod <= '0;
        rcon <= 8'h01;
        iss  <= 1'b0;
`ifdef KS_WIDE_KEY_EN
        len_q <= bus.key_len;
`endif
      end else begin
        if (LAT1 && sub && !iss) iss <= 1'b1;
        if (xfer) begin
          iss <= 1'b0;
          st  <= {st[SB-2:0], dat};
          cnt <= last_b ? 8'd0 : cnt + 8'd1;
          if (cnt[1:0] == 2'd3) begin
            wmod <= (wmod == wmax) ? 3'd0 : wmod + 3'd1;
            if (state == EXPAND && rot)
              rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
          end
        end
      end
    end
  end

endmodule
